// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for the 8-bit add/subtract ALU board top level:
// button debounce, operand entry FSM, result capture and 7-segment scan.
module alu_seq_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SCAN_CYCLES     = 100000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [15:0] Sw,
    input  logic [2:0]  Btn,
    input  logic [8:0]  AluResult,
    output logic [7:0]  OpX,
    output logic [7:0]  OpY,
    output logic        Cin,
    output logic        Sel,
    output logic [8:0]  Result,
    output logic [1:0]  DigitSel,
    output logic [7:0]  AN,
    output logic        Busy,
    output logic        Done
);

    localparam int unsigned DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

    typedef enum logic [1:0] {
        LOAD_X,
        LOAD_Y,
        EXEC,
        SHOW
    } state_t;

    logic unused_inputs;
    assign unused_inputs = ^{Btn[2], Sw[14:9]};

    // ---------------- button conditioning (index 0 = step, 1 = clear)
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    level_q, level_d;
    logic [1:0]    strobe_q, strobe_d;
    logic [DW-1:0] cnt_q [2];
    logic [DW-1:0] cnt_d [2];

    always_comb begin
        level_d  = level_q;
        strobe_d = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    level_d[i]  = sync2_q[i];
                    strobe_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            level_q  <= '0;
            strobe_q <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            sync1_q  <= Btn[1:0];
            sync2_q  <= sync1_q;
            level_q  <= level_d;
            strobe_q <= strobe_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
        end
    end

    // ---------------- operand entry FSM
    state_t      state_q, state_d;
    logic [7:0]  opx_q, opx_d, opy_q, opy_d;
    logic        cin_q, cin_d, sel_q, sel_d;
    logic [8:0]  result_q, result_d;
    logic        busy_q, busy_d, done_q, done_d;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= LOAD_X;
            opx_q    <= '0;
            opy_q    <= '0;
            cin_q    <= 1'b0;
            sel_q    <= 1'b1;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opx_q    <= opx_d;
            opy_q    <= opy_d;
            cin_q    <= cin_d;
            sel_q    <= sel_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opx_d    = opx_q;
        opy_d    = opy_q;
        cin_d    = cin_q;
        sel_d    = sel_q;
        result_d = result_q;
        // Clear takes priority and swallows a coincident step.
        if (strobe_q[1]) begin
            state_d  = LOAD_X;
            opx_d    = '0;
            opy_d    = '0;
            cin_d    = 1'b0;
            sel_d    = 1'b1;
            result_d = '0;
        end else begin
            unique case (state_q)
                LOAD_X: if (strobe_q[0]) begin
                    opx_d   = Sw[7:0];
                    state_d = LOAD_Y;
                end
                LOAD_Y: if (strobe_q[0]) begin
                    opy_d   = Sw[7:0];
                    cin_d   = Sw[8];
                    sel_d   = Sw[15];
                    state_d = EXEC;
                end
                EXEC: begin
                    result_d = AluResult;
                    state_d  = SHOW;
                end
                SHOW: if (strobe_q[0]) state_d = LOAD_X;
                default: state_d = LOAD_X;
            endcase
        end
    end

    // Status flags are decoded from the next state so they leave as flops.
    always_comb begin
        busy_d = (state_d == LOAD_Y) || (state_d == EXEC);
        done_d = (state_d == SHOW);
    end

    // ---------------- display scan
    logic [SW-1:0] scan_q, scan_d;
    logic [1:0]    digit_q, digit_d;
    logic [7:0]    an_q, an_d;

    always_comb begin
        scan_d  = scan_q + 1'b1;
        digit_d = digit_q;
        if (scan_q == SW'(SCAN_CYCLES - 1)) begin
            scan_d  = '0;
            digit_d = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
        end
        unique case (digit_d)
            2'd0:    an_d = 8'hFE;
            2'd1:    an_d = 8'hFD;
            2'd2:    an_d = 8'hFB;
            default: an_d = '1;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            scan_q  <= '0;
            digit_q <= '0;
            an_q    <= '1;
        end else begin
            scan_q  <= scan_d;
            digit_q <= digit_d;
            an_q    <= an_d;
        end
    end

    assign OpX      = opx_q;
    assign OpY      = opy_q;
    assign Cin      = cin_q;
    assign Sel      = sel_q;
    assign Result   = result_q;
    assign DigitSel = digit_q;
    assign AN       = an_q;
    assign Busy     = busy_q;
    assign Done     = done_q;

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequencing controller for the 8-bit add/subtract ALU datapath on the board top level.
- Turns raw push buttons into debounced one-cycle press strobes.
- Walks the operator through operand entry: latch OpX, then latch OpY/Cin/op select.
- Captures the 9-bit ALU result into a holding register.
- Time-multiplexes the seven-segment anodes and digit select so the result stays on display.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable samples needed to accept a button level (10 ms at 100 MHz); minimum 2
SCAN_CYCLES, 100000, clock cycles each display digit stays active; minimum 1

Ports:
Clk  input  1  system clock, all state on rising edge
Rst  input  1  asynchronous, active-high reset
Sw  input  16  slide switches; Sw[7:0] operand, Sw[8] carry/borrow-in, Sw[15] op select
Btn  input  3  raw buttons; Btn[0] step, Btn[1] clear, Btn[2] unused (tie-off, ignored)
AluResult  input  9  combinational ALU output {carry/borrow, 8-bit sum/diff}
OpX  output  8  registered operand X to ALU
OpY  output  8  registered operand Y to ALU
Cin  output  1  registered carry/borrow-in to ALU
Sel  output  1  registered op select: 1 = add, 0 = subtract
Result  output  9  captured ALU result
DigitSel  output  2  hex digit index for display mux: 0 = Result[3:0], 1 = Result[7:4], 2 = {3'b000, Result[8]}
AN  output  8  anode enables, active-low
Busy  output  1  high in LOAD_Y and EXEC
Done  output  1  high in SHOW

Behaviour:
Reset (async, Rst=1):
- OpX, OpY, Result = 0; Cin = 0; Sel = 1.
- FSM = LOAD_X.
- Debouncers: accepted level = 0, counter = 0.
- Scan counter = 0, DigitSel = 0, AN = 8'hFF.
- Busy = 0, Done = 0.
- Reset mid-operation abandons any entry and any pending strobe.

Button conditioning (Btn[0] and Btn[1], independent):
- Each button passes through a 2-flop synchronizer.
- Per-button counter increments while the synchronized level differs from the accepted level and clears when they match.
- When the counter reaches DEBOUNCE_CYCLES-1, the accepted level flips and the counter clears.
- A press strobe is a single Clk cycle on an accepted 0->1 transition. Release produces no strobe.
- Press latency from raw edge to strobe is DEBOUNCE_CYCLES+2 cycles.
- Bounces shorter than DEBOUNCE_CYCLES produce no strobe.

FSM (states LOAD_X, LOAD_Y, EXEC, SHOW):
- LOAD_X: on step strobe, OpX <= Sw[7:0]; go to LOAD_Y.
- LOAD_Y: on step strobe, OpY <= Sw[7:0], Cin <= Sw[8], Sel <= Sw[15]; go to EXEC.
- EXEC: one-cycle settle state with no capture; unconditionally go to SHOW.
- SHOW entry: Result <= AluResult on the EXEC->SHOW clock edge, i.e. 2 cycles after the LOAD_Y step strobe.
- SHOW: Result holds; on step strobe go to LOAD_X. Registers keep their values until overwritten.
- Clear strobe in any state: OpX, OpY, Result = 0; Cin = 0; Sel = 1; go to LOAD_X.
- Simultaneous clear and step strobes: clear wins, step is dropped.
- A step strobe arriving during EXEC is dropped.
- Switch changes outside a step strobe have no effect on the registered outputs.

Display scan:
- Free-running in every state: scan counter counts 0..SCAN_CYCLES-1, then wraps.
- On each wrap, DigitSel advances 0 -> 1 -> 2 -> 0. Values 3 never occur.
- AN is registered and driven low only for the selected digit: DigitSel 0 gives 8'hFE, 1 gives 8'hFD, 2 gives 8'hFB.
- AN[7:3] are always 1.
- AN and DigitSel change on the same edge; AN is never all-ones after the first cycle following reset.

Outputs: all registered. No combinational path from Sw, Btn or AluResult to any output.

Test Plan:
Bench uses DEBOUNCE_CYCLES=4, SCAN_CYCLES=2, and a behavioural ALU model (AluResult = Sel ? OpX+OpY+Cin : OpX-OpY-Cin, 9-bit).

1. Reset, then Sw=16'h0025, press step; Sw=16'h8113, press step -> OpX=8'h25, OpY=8'h13, Cin=1, Sel=1; Done rises 2 cycles after the second strobe; Result=9'h039.
2. OpX=8'h10, then Sw=16'h0020 (Sel=0, Cin=0) with step -> Result=9'h1F0 (borrow set, Diff=8'hF0); DigitSel sequence 0,1,2 shows 0, F, 1.
3. Btn[0] toggles 1,0,1 at 2-cycle spacing, then holds 1 -> exactly one strobe, DEBOUNCE_CYCLES+2 cycles after the final stable edge; FSM advances one state.
4. In SHOW, assert Btn[0] and Btn[1] together for 20 cycles -> FSM=LOAD_X; OpX=OpY=Result=0; Sel=1; no advance to LOAD_Y.
5. Assert Rst asynchronously mid-LOAD_Y (no clock edge) -> all outputs take reset values immediately; after release, FSM is in LOAD_X.
6. Idle for 12 cycles -> AN cycles FE, FE, FD, FD, FB, FB, then repeats; DigitSel tracks AN; AN[7:3] constant 1.
